// File: rtl/mem_arb_pkg.sv
// Shared types for the program/data RAM arbiter: command codes, lock FSM
// states and the read-return owner tag.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    OPEN,
    LOCKED,
    YIELD
  } lock_state_t;

  typedef enum logic [1:0] {
    NONE,
    CPU,
    LDR
  } owner_t;

  // Code 2'b11 is reserved and behaves as MNONE.
  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == 2'(MREAD)) || (cmd == 2'(MWRITE));
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker: fixed priority (port 0 wins) or round-robin
// toward the port not granted most recently, with per-port block mask.
module arb_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_en,
  input  logic i_last1,
  input  logic i_block0,
  input  logic i_block1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic w_r0;
  logic w_r1;

  always_comb begin
    w_r0   = i_req0 && !i_block0;
    w_r1   = i_req1 && !i_block1;
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (w_r0 && w_r1) begin
      if (i_rr_en && !i_last1) o_gnt1 = 1'b1;
      else                     o_gnt0 = 1'b1;
    end else begin
      o_gnt0 = w_r0;
      o_gnt1 = w_r1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between CPU (port 0) and loader (port 1),
// with bounded loader lock and range checking. Optional: MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 256,
  parameter int RR_EN     = 0,
  parameter int LOCK_MAX  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   cpu_cmd,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_gnt,
  output logic                         cpu_rvalid,
  output logic [DATA_W-1:0]            cpu_rdata,
  input  logic [1:0]                   ldr_cmd,
  input  logic [ADDR_W-1:0]            ldr_addr,
  input  logic [DATA_W-1:0]            ldr_wdata,
  input  logic                         ldr_lock,
  output logic                         ldr_gnt,
  output logic                         ldr_rvalid,
  output logic [DATA_W-1:0]            ldr_rdata,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
  output logic                         ram_we,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic                         err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]                  stat_cpu_gnts,
  output logic [15:0]                  stat_ldr_gnts,
  output logic [15:0]                  stat_conflicts
`endif
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int CNT_W  = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_YLD = CNT_W'(LOCK_MAX - 1);

  lock_state_t        r_state;
  lock_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_lock_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_last_ldr;
  owner_t             r_owner;
  logic               r_rd_oor;
  logic               r_err;

  logic               w_cpu_req, w_ldr_req, w_cpu_oor, w_ldr_oor;
  logic               w_pick_cpu, w_pick_ldr, w_gnt_cpu, w_gnt_ldr;
  logic               w_block_cpu, w_rr_mode;
  logic [1:0]         w_sel_cmd;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_oor;
  logic               w_sel_read;

  assign w_cpu_req = is_req(cpu_cmd);
  assign w_ldr_req = is_req(ldr_cmd);
  assign w_cpu_oor = 32'(cpu_addr) >= 32'(MEM_WORDS);
  assign w_ldr_oor = 32'(ldr_addr) >= 32'(MEM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= OPEN;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= (r_state == LOCKED) ? w_cnt_inc : '0;
    end
  end

  // Forced release is judged on the post-increment count, so the loader holds
  // the bus for LOCK_MAX granted cycles including the one that took the lock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_inc   = (r_lock_cnt == CNT_SAT) ? r_lock_cnt : r_lock_cnt + 1'b1;
    case (r_state)
      OPEN:    if (w_gnt_ldr && ldr_lock) w_state_nxt = LOCKED;
      LOCKED: begin
        if (!ldr_lock)                w_state_nxt = OPEN;
        else if (w_cnt_inc >= CNT_YLD) w_state_nxt = YIELD;
      end
      YIELD:   w_state_nxt = OPEN;
      default: w_state_nxt = OPEN;
    endcase
  end

  always_comb begin
    w_block_cpu = (r_state == LOCKED);
    w_rr_mode   = (RR_EN != 0) && (r_state == OPEN);
  end

  arb_pick u_pick (
    .i_req0   (w_cpu_req),
    .i_req1   (w_ldr_req),
    .i_rr_en  (w_rr_mode),
    .i_last1  (r_last_ldr),
    .i_block0 (w_block_cpu),
    .i_block1 (1'b0),
    .o_gnt0   (w_pick_cpu),
    .o_gnt1   (w_pick_ldr)
  );

  assign w_gnt_cpu = w_pick_cpu && !reset;
  assign w_gnt_ldr = w_pick_ldr && !reset;

  always_comb begin
    w_sel_cmd   = 2'(MNONE);
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_oor   = 1'b0;
    if (w_gnt_cpu) begin
      w_sel_cmd   = cpu_cmd;
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
      w_sel_oor   = w_cpu_oor;
    end else if (w_gnt_ldr) begin
      w_sel_cmd   = ldr_cmd;
      w_sel_addr  = ldr_addr;
      w_sel_wdata = ldr_wdata;
      w_sel_oor   = w_ldr_oor;
    end
    w_sel_read = (w_sel_cmd == 2'(MREAD));
  end

  always_comb begin
    cpu_gnt    = w_gnt_cpu;
    ldr_gnt    = w_gnt_ldr;
    ram_we     = (w_sel_cmd == 2'(MWRITE)) && !w_sel_oor;
    ram_addr   = w_sel_oor ? '0 : w_sel_addr[RAM_AW-1:0];
    ram_wdata  = ram_we ? w_sel_wdata : '0;
    cpu_rvalid = !reset && (r_owner == CPU);
    ldr_rvalid = !reset && (r_owner == LDR);
    cpu_rdata  = (cpu_rvalid && !r_rd_oor) ? ram_rdata : '0;
    ldr_rdata  = (ldr_rvalid && !r_rd_oor) ? ram_rdata : '0;
    err        = r_err && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner    <= NONE;
      r_rd_oor   <= 1'b0;
      r_err      <= 1'b0;
      r_last_ldr <= 1'b1;
    end else begin
      r_owner  <= !w_sel_read ? NONE : (w_gnt_cpu ? CPU : LDR);
      r_rd_oor <= w_sel_oor;
      r_err    <= w_sel_oor;
      if (w_gnt_cpu)      r_last_ldr <= 1'b0;
      else if (w_gnt_ldr) r_last_ldr <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_cpu, r_stat_ldr, r_stat_cfl;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_cpu <= '0;
      r_stat_ldr <= '0;
      r_stat_cfl <= '0;
    end else begin
      if (w_gnt_cpu && (r_stat_cpu != '1)) r_stat_cpu <= r_stat_cpu + 16'd1;
      if (w_gnt_ldr && (r_stat_ldr != '1)) r_stat_ldr <= r_stat_ldr + 16'd1;
      // A blocked loader in LOCKED/YIELD always coincides with a CPU request.
      if (w_cpu_req && w_ldr_req && (r_stat_cfl != '1)) r_stat_cfl <= r_stat_cfl + 16'd1;
    end
  end

  assign stat_cpu_gnts  = r_stat_cpu;
  assign stat_ldr_gnts  = r_stat_ldr;
  assign stat_conflicts = r_stat_cfl;
`endif

endmodule
